// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
//
// Read-side master for a synchronous FIFO with a one-cycle registered read
// latency. It issues rd_en only when the FIFO is non-empty and there is room
// downstream for the word that will come back. Returned words are presented
// in order on a valid/ready stream through a two-entry output buffer: a head
// register that drives the stream, and a skid register behind it.
//
// Ports
//   clk             single clock, all logic on posedge
//   rst             synchronous, active-high reset
//   enable          1 = keep fetching from the FIFO, 0 = stop fetching and drain
//   clr_err         synchronous pulse that clears underflow_err
//   fifo_rd_en      read strobe to the FIFO
//   fifo_data_out   FIFO read data, valid the cycle after an accepted read
//   fifo_empty      FIFO empty flag
//   fifo_underflow  FIFO underflow flag
//   m_valid         output word valid
//   m_ready         consumer ready
//   m_data          output word
//   busy            not idle, or holding buffered or in-flight data
//   rd_count        beats delivered on the stream, wraps modulo 2^CNT_W
//   underflow_err   sticky record that fifo_underflow was seen high
// ---------------------------------------------------------------------------
module fifo_stream_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clr_err,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic [CNT_W-1:0]      rd_count,
  output logic                  underflow_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Buffer bookkeeping: occ counts valid entries (0..2), inflight marks a
  // read issued last cycle whose data arrives on fifo_data_out this cycle.
  logic [1:0]            occ;
  logic                  inflight;
  logic [FIFO_WIDTH-1:0] head_q;
  logic [FIFO_WIDTH-1:0] skid_q;

  logic                  pop;
  logic                  capture;
  logic [2:0]            level;
  logic [2:0]            limit;

  // The head entry drives the stream directly, so m_data cannot change
  // while a beat is stalled: the head is only rewritten on a pop or when
  // the buffer is empty.
  assign m_valid = (occ != 2'd0);
  assign m_data  = head_q;
  assign pop     = m_valid && m_ready;
  assign capture = inflight;

  // Space check: entries held plus the word already in flight, minus the
  // entry leaving this cycle, must stay below two so the word requested
  // now always has a slot when it lands. Written as level < 2 + pop to
  // keep the arithmetic unsigned.
  assign level = {1'b0, occ} + {2'b00, inflight};
  assign limit = 3'd2 + {2'b00, pop};

  // The FIFO updates its count on the same edge as the read, so empty is
  // used as-is with no extra guard cycle.
  assign fifo_rd_en = (state == RUN) && !fifo_empty && (level < limit);

  assign busy = (state != IDLE) || (occ != 2'd0) || inflight;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Re-enabling during DRAIN takes priority over the
  // return to IDLE; DRAIN only finishes once nothing is buffered or in
  // flight, so dropping enable never strands a word.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (enable) begin
          state_nxt = RUN;
        end else if ((occ == 2'd0) && !inflight) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output buffer. Reset drops both the held entries and any word still
  // in flight, so nothing read before reset can surface afterwards.
  // A capture with no pop lands in the first free entry; a pop with no
  // capture shifts the skid into the head; both together keep occ fixed
  // and advance the head. Capture into a full buffer cannot occur because
  // of the space check on fifo_rd_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      head_q   <= '0;
      skid_q   <= '0;
    end else begin
      inflight <= fifo_rd_en;
      case ({capture, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            head_q <= fifo_data_out;
            occ    <= 2'd1;
          end else if (occ == 2'd1) begin
            skid_q <= fifo_data_out;
            occ    <= 2'd2;
          end
        end
        2'b01: begin
          if (occ == 2'd2) begin
            head_q <= skid_q;
          end
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head_q <= fifo_data_out;
          end else begin
            head_q <= skid_q;
            skid_q <= fifo_data_out;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Delivered-beat counter, wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
    end else if (pop) begin
      rd_count <= rd_count + 1'b1;
    end
  end

  // Sticky underflow flag. A new underflow in the same cycle as clr_err
  // keeps the flag set so the event is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_err <= 1'b0;
    end else if (fifo_underflow) begin
      underflow_err <= 1'b1;
    end else if (clr_err) begin
      underflow_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_stream_reader
//
// Self-checking bench for fifo_stream_reader. A behavioural FIFO with a
// registered read port feeds the DUT; every word pushed into it is also
// queued as an expected beat and popped when the stream delivers a beat.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// ---------------------------------------------------------------------------
module tb_fifo_stream_reader;

  localparam int W  = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          clr_err;
  logic          m_ready;
  logic          force_uf;
  logic          fifo_rd_en;
  logic          fifo_empty;
  logic          fifo_underflow;
  logic          m_valid;
  logic          busy;
  logic          underflow_err;
  logic [W-1:0]  fifo_data_out;
  logic [W-1:0]  m_data;
  logic [CW-1:0] rd_count;

  // FIFO model: write side owned by the initial block, read side by the
  // posedge process below.
  logic [W-1:0]  fifo_mem [0:255];
  int            wr_ptr      = 0;
  int            rd_ptr      = 0;
  logic          fifo_flush  = 1'b0;
  logic          uf_model    = 1'b0;
  int            empty_reads = 0;

  logic [W-1:0]  exp_q [$];
  logic [CW-1:0] exp_count = '0;
  int            checks    = 0;
  int            passes    = 0;

  fifo_stream_reader #(
    .FIFO_WIDTH (W),
    .CNT_W      (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .clr_err        (clr_err),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_data_out  (fifo_data_out),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .busy           (busy),
    .rd_count       (rd_count),
    .underflow_err  (underflow_err)
  );

  always #5 clk = ~clk;

  assign fifo_empty     = (wr_ptr == rd_ptr);
  assign fifo_underflow = uf_model | force_uf;

  // Registered-read FIFO; a read of an empty FIFO raises underflow.
  always @(posedge clk) begin
    uf_model <= fifo_rd_en && fifo_empty;
    if (fifo_rd_en && fifo_empty) begin
      empty_reads <= empty_reads + 1;
    end
    if (fifo_flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_data_out <= fifo_mem[rd_ptr % 256];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  task automatic push_word(input logic [W-1:0] d);
    fifo_mem[wr_ptr % 256] = d;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(d);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; clr_err = 1'b0; m_ready = 1'b0; force_uf = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) $display("[TB] FAIL reset_m_valid: got %b, expected 0", m_valid); else passes++;
    checks++; if (m_data !== 16'h0000) $display("[TB] FAIL reset_m_data: got %h, expected 0000", m_data); else passes++;
    checks++; if (rd_count !== 4'd0) $display("[TB] FAIL reset_rd_count: got %0d, expected 0", rd_count); else passes++;
    checks++; if (underflow_err !== 1'b0) $display("[TB] FAIL reset_underflow_err: got %b, expected 0", underflow_err); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b, expected 0", busy); else passes++;
    checks++; if (fifo_rd_en !== 1'b0) $display("[TB] FAIL reset_rd_en: got %b, expected 0", fifo_rd_en); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    int first_c;
    int last_c;
    int beats;
    logic [W-1:0] exp;
    first_c = -1; last_c = -1; beats = 0;
    for (int i = 1; i <= 8; i++) push_word(W'(i));
    enable = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL stream_beat: got %h, expected no beat", m_data);
        else begin
          exp = exp_q.pop_front();
          if (m_data !== exp) $display("[TB] FAIL stream_beat: got %h, expected %h", m_data, exp); else passes++;
        end
        exp_count++; beats++;
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      @(posedge clk); #1;
    end
    checks++; if (beats != 8) $display("[TB] FAIL stream_count: got %0d beats, expected 8", beats); else passes++;
    checks++; if (last_c - first_c != 7) $display("[TB] FAIL stream_back_to_back: got span %0d, expected 7", last_c - first_c); else passes++;
    checks++; if (rd_count !== 4'd8) $display("[TB] FAIL stream_rd_count: got %0d, expected 8", rd_count); else passes++;
    checks++; if (empty_reads != 0) $display("[TB] FAIL stream_empty_read: got %0d, expected 0", empty_reads); else passes++;
    enable = 1'b0;
    for (int c = 0; c < 20 && busy; c++) begin @(negedge clk); @(posedge clk); #1; end
    checks++; if (busy !== 1'b0) $display("[TB] FAIL stream_idle: got busy %b, expected 0", busy); else passes++;
  endtask

  task automatic test_backpressure();
    int held_bad;
    logic [W-1:0] exp;
    held_bad = 0;
    for (int i = 1; i <= 4; i++) push_word(W'(i));
    enable = 1'b1; m_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c >= 3 && (m_valid !== 1'b1 || m_data !== 16'h0001)) held_bad++;
      if (c == 5) begin
        checks++; if (fifo_rd_en !== 1'b0) $display("[TB] FAIL bp_rd_en: got %b, expected 0", fifo_rd_en); else passes++;
        checks++; if (wr_ptr - rd_ptr != 2) $display("[TB] FAIL bp_fifo_left: got %0d, expected 2", wr_ptr - rd_ptr); else passes++;
      end
      @(posedge clk); #1;
    end
    checks++; if (held_bad != 0) $display("[TB] FAIL bp_hold: got %0d unstable cycles, expected 0", held_bad); else passes++;
    m_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL bp_beat: got %h, expected no beat", m_data);
        else begin
          exp = exp_q.pop_front();
          if (m_data !== exp) $display("[TB] FAIL bp_beat: got %h, expected %h", m_data, exp); else passes++;
        end
        exp_count++;
      end
      @(posedge clk); #1;
    end
    checks++; if (exp_q.size() != 0) $display("[TB] FAIL bp_missing: got %0d undelivered, expected 0", exp_q.size()); else passes++;
    enable = 1'b0;
    for (int c = 0; c < 20 && busy; c++) begin @(negedge clk); @(posedge clk); #1; end
    checks++; if (rd_count !== exp_count) $display("[TB] FAIL bp_rd_count: got %0d, expected %0d", rd_count, exp_count); else passes++;
  endtask

  task automatic test_drain();
    int pulses;
    int beats;
    logic [W-1:0] exp;
    pulses = 0; beats = 0;
    for (int i = 1; i <= 6; i++) push_word(16'h0030 + W'(i));
    enable = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fifo_rd_en) pulses++;
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL drain_beat: got %h, expected no beat", m_data);
        else begin
          exp = exp_q.pop_front();
          if (m_data !== exp) $display("[TB] FAIL drain_beat: got %h, expected %h", m_data, exp); else passes++;
        end
        exp_count++; beats++;
      end
      @(posedge clk); #1;
      if (pulses >= 2) enable = 1'b0;
    end
    checks++; if (pulses != 3) $display("[TB] FAIL drain_reads: got %0d, expected 3", pulses); else passes++;
    checks++; if (beats != 3) $display("[TB] FAIL drain_delivered: got %0d, expected 3", beats); else passes++;
    checks++; if (wr_ptr - rd_ptr != 3) $display("[TB] FAIL drain_fifo_left: got %0d, expected 3", wr_ptr - rd_ptr); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL drain_idle: got busy %b, expected 0", busy); else passes++;
    fifo_flush = 1'b1;
    @(posedge clk); #1;
    fifo_flush = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_empty_boundary();
    int pulses;
    int uf_seen;
    logic [W-1:0] exp;
    pulses = 0; uf_seen = 0;
    push_word(16'hBEEF);
    enable = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (fifo_rd_en) pulses++;
      if (fifo_underflow) uf_seen++;
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL empty_beat: got %h, expected no beat", m_data);
        else begin
          exp = exp_q.pop_front();
          if (m_data !== exp) $display("[TB] FAIL empty_beat: got %h, expected %h", m_data, exp); else passes++;
        end
        exp_count++;
      end
      @(posedge clk); #1;
    end
    checks++; if (pulses != 1) $display("[TB] FAIL empty_reads: got %0d, expected 1", pulses); else passes++;
    checks++; if (uf_seen != 0) $display("[TB] FAIL empty_underflow: got %0d, expected 0", uf_seen); else passes++;
    checks++; if (underflow_err !== 1'b0) $display("[TB] FAIL empty_err: got %b, expected 0", underflow_err); else passes++;
    checks++; if (empty_reads != 0) $display("[TB] FAIL empty_read_of_empty: got %0d, expected 0", empty_reads); else passes++;
    checks++; if (rd_count !== exp_count) $display("[TB] FAIL empty_rd_count: got %0d, expected %0d", rd_count, exp_count); else passes++;
    enable = 1'b0;
    for (int c = 0; c < 20 && busy; c++) begin @(negedge clk); @(posedge clk); #1; end
  endtask

  task automatic test_wrap_err();
    int beats;
    logic [W-1:0] exp;
    beats = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; exp_count = '0;
    for (int i = 0; i < 17; i++) push_word(16'h0100 + W'(i));
    enable = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL wrap_beat: got %h, expected no beat", m_data);
        else begin
          exp = exp_q.pop_front();
          if (m_data !== exp) $display("[TB] FAIL wrap_beat: got %h, expected %h", m_data, exp); else passes++;
        end
        exp_count++; beats++;
      end
      @(posedge clk); #1;
    end
    enable = 1'b0;
    for (int c = 0; c < 20 && busy; c++) begin @(negedge clk); @(posedge clk); #1; end
    checks++; if (beats != 17) $display("[TB] FAIL wrap_beats: got %0d, expected 17", beats); else passes++;
    checks++; if (rd_count !== 4'd1) $display("[TB] FAIL wrap_rd_count: got %0d, expected 1", rd_count); else passes++;
    force_uf = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    force_uf = 1'b0;
    @(negedge clk);
    checks++; if (underflow_err !== 1'b1) $display("[TB] FAIL err_set: got %b, expected 1", underflow_err); else passes++;
    repeat (2) begin @(posedge clk); #1; @(negedge clk); end
    checks++; if (underflow_err !== 1'b1) $display("[TB] FAIL err_sticky: got %b, expected 1", underflow_err); else passes++;
    @(posedge clk); #1;
    clr_err = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    clr_err = 1'b0;
    @(negedge clk);
    checks++; if (underflow_err !== 1'b0) $display("[TB] FAIL err_clear: got %b, expected 0", underflow_err); else passes++;
    @(posedge clk); #1;
    clr_err = 1'b1; force_uf = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    clr_err = 1'b0; force_uf = 1'b0;
    @(negedge clk);
    checks++; if (underflow_err !== 1'b1) $display("[TB] FAIL err_set_wins: got %b, expected 1", underflow_err); else passes++;
    @(posedge clk); #1;
    clr_err = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    clr_err = 1'b0;
  endtask

  task automatic test_reset_midstream();
    int stale;
    for (int i = 1; i <= 4; i++) push_word(16'h0200 + W'(i));
    enable = 1'b1; m_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin @(negedge clk); @(posedge clk); #1; end
    checks++; if (m_valid !== 1'b1 || fifo_rd_en !== 1'b0) $display("[TB] FAIL rst_pre_full: got valid %b rd_en %b, expected 1 0", m_valid, fifo_rd_en); else passes++;
    rst = 1'b1; enable = 1'b0;
    @(negedge clk); @(posedge clk); #1;
    rst = 1'b0; exp_count = '0; exp_q.delete();
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) $display("[TB] FAIL rst_mid_m_valid: got %b, expected 0", m_valid); else passes++;
    checks++; if (rd_count !== 4'd0) $display("[TB] FAIL rst_mid_rd_count: got %0d, expected 0", rd_count); else passes++;
    checks++; if (m_data !== 16'h0000) $display("[TB] FAIL rst_mid_m_data: got %h, expected 0000", m_data); else passes++;
    @(posedge clk); #1;
    fifo_flush = 1'b1;
    @(posedge clk); #1;
    fifo_flush = 1'b0;
    // Second pass: reset lands while a read is in flight.
    for (int i = 1; i <= 4; i++) push_word(16'h0300 + W'(i));
    enable = 1'b1; m_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin @(negedge clk); @(posedge clk); #1; end
    rst = 1'b1; enable = 1'b0;
    @(negedge clk); @(posedge clk); #1;
    rst = 1'b0; m_ready = 1'b1; exp_q.delete();
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m_valid !== 1'b0 || m_data !== 16'h0000) stale++;
      @(posedge clk); #1;
    end
    checks++; if (stale != 0) $display("[TB] FAIL rst_stale_capture: got %0d cycles with data, expected 0", stale); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b, expected 0", busy); else passes++;
  endtask

  initial begin
    $display("[TB] fifo_stream_reader bench start");
    test_reset();
    test_stream();
    test_backpressure();
    test_drain();
    test_empty_boundary();
    test_wrap_err();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
